// File: rtl/vga_cell_painter.sv
// Pixel-write sequencer for vga_adapter: arbitrates two cell-paint requesters and a playfield
// clear, then rasterises the granted rectangle one pixel per clock.
module vga_cell_painter #(
    parameter int unsigned CELL      = 5,
    parameter int unsigned GRID_W    = 10,
    parameter int unsigned GRID_H    = 20,
    parameter int unsigned ORIGIN_X  = 55,
    parameter int unsigned ORIGIN_Y  = 10,
    parameter logic [8:0]  CLR_COLOR = 9'd0
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic [3:0] a_col_i,
    input  logic [4:0] a_row_i,
    input  logic [8:0] a_color_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    input  logic [3:0] b_col_i,
    input  logic [4:0] b_row_i,
    input  logic [8:0] b_color_i,
    input  logic       clr_valid_i,
    output logic       clr_ready_o,
    output logic [7:0] x_o,
    output logic [6:0] y_o,
    output logic [8:0] color_o,
    output logic       write_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int unsigned CellLast = CELL - 1;
    localparam int unsigned ClrWLast = GRID_W * CELL - 1;
    localparam int unsigned ClrHLast = GRID_H * CELL - 1;

    typedef enum logic [1:0] {StIdle, StCell, StClear} state_e;

    state_e     state_q, state_d;
    logic       prio_b_q, prio_b_d;
    logic [7:0] px_q, px_d;
    logic [6:0] py_q, py_d;
    logic [7:0] wlast_q, wlast_d;
    logic [6:0] hlast_q, hlast_d;
    logic [7:0] bx_q, bx_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [8:0] color_q, color_d;
    logic       write_q, write_d;
    logic       err_q, err_d;

    logic       idle;
    logic       a_grant, b_grant, clr_grant;
    logic [3:0] sel_col;
    logic [4:0] sel_row;
    logic [8:0] sel_color;
    logic       sel_in_range;
    logic [7:0] cell_x;
    logic [6:0] cell_y;

    // Clear wins; A/B alternate when both wait, prio_b_q marks B as the one not served last.
    always_comb begin
        idle      = (state_q == StIdle);
        clr_grant = idle && clr_valid_i;
        a_grant   = idle && !clr_valid_i && a_valid_i && (!b_valid_i || !prio_b_q);
        b_grant   = idle && !clr_valid_i && b_valid_i && (!a_valid_i || prio_b_q);
    end

    assign a_ready_o   = a_grant;
    assign b_ready_o   = b_grant;
    assign clr_ready_o = clr_grant;

    always_comb begin
        sel_col      = a_grant ? a_col_i : b_col_i;
        sel_row      = a_grant ? a_row_i : b_row_i;
        sel_color    = a_grant ? a_color_i : b_color_i;
        sel_in_range = (32'(sel_col) < GRID_W) && (32'(sel_row) < GRID_H);
        cell_x       = 8'(ORIGIN_X + 32'(sel_col) * CELL);
        cell_y       = 7'(ORIGIN_Y + 32'(sel_row) * CELL);
    end

    always_comb begin
        state_d  = state_q;
        prio_b_d = prio_b_q;
        px_d     = px_q;
        py_d     = py_q;
        wlast_d  = wlast_q;
        hlast_d  = hlast_q;
        bx_d     = bx_q;
        x_d      = x_q;
        y_d      = y_q;
        color_d  = color_q;
        write_d  = write_q;
        err_d    = 1'b0;

        unique case (state_q)
            StIdle: begin
                write_d = 1'b0;
                if (clr_grant) begin
                    state_d = StClear;
                    px_d    = 8'd0;
                    py_d    = 7'd0;
                    wlast_d = 8'(ClrWLast);
                    hlast_d = 7'(ClrHLast);
                    bx_d    = 8'(ORIGIN_X);
                    x_d     = 8'(ORIGIN_X);
                    y_d     = 7'(ORIGIN_Y);
                    color_d = CLR_COLOR;
                    write_d = 1'b1;
                end else if (a_grant || b_grant) begin
                    prio_b_d = a_grant;
                    if (sel_in_range) begin
                        state_d = StCell;
                        px_d    = 8'd0;
                        py_d    = 7'd0;
                        wlast_d = 8'(CellLast);
                        hlast_d = 7'(CellLast);
                        bx_d    = cell_x;
                        x_d     = cell_x;
                        y_d     = cell_y;
                        color_d = sel_color;
                        write_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StCell, StClear: begin
                // Outputs already show pixel (px_q, py_q); step to the next or finish.
                if (px_q == wlast_q) begin
                    if (py_q == hlast_q) begin
                        state_d = StIdle;
                        write_d = 1'b0;
                    end else begin
                        px_d = 8'd0;
                        py_d = py_q + 7'd1;
                        x_d  = bx_q;
                        y_d  = y_q + 7'd1;
                    end
                end else begin
                    px_d = px_q + 8'd1;
                    x_d  = x_q + 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                write_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= StIdle;
            prio_b_q <= 1'b0;
            px_q     <= 8'd0;
            py_q     <= 7'd0;
            wlast_q  <= 8'd0;
            hlast_q  <= 7'd0;
            bx_q     <= 8'd0;
            x_q      <= 8'd0;
            y_q      <= 7'd0;
            color_q  <= 9'd0;
            write_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            prio_b_q <= prio_b_d;
            px_q     <= px_d;
            py_q     <= py_d;
            wlast_q  <= wlast_d;
            hlast_q  <= hlast_d;
            bx_q     <= bx_d;
            x_q      <= x_d;
            y_q      <= y_d;
            color_q  <= color_d;
            write_q  <= write_d;
            err_q    <= err_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign color_o = color_q;
    assign write_o = write_q;
    assign busy_o  = (state_q != StIdle);
    assign err_o   = err_q;

endmodule

// File: tb/tb_vga_cell_painter.sv
// Directed bench for vga_cell_painter: table of single-cell paints plus hand-written
// sequences for reset, round-robin, clear priority and sample-on-accept.
module tb_vga_cell_painter;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       a_valid = 1'b0, b_valid = 1'b0, clr_valid = 1'b0;
    logic       a_ready, b_ready, clr_ready;
    logic [3:0] a_col = '0, b_col = '0;
    logic [4:0] a_row = '0, b_row = '0;
    logic [8:0] a_color = '0, b_color = '0;
    logic [7:0] x;
    logic [6:0] y;
    logic [8:0] color;
    logic       write, busy, err;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    vga_cell_painter dut (
        .clock_i     (clock),
        .reset_i     (reset),
        .a_valid_i   (a_valid),
        .a_ready_o   (a_ready),
        .a_col_i     (a_col),
        .a_row_i     (a_row),
        .a_color_i   (a_color),
        .b_valid_i   (b_valid),
        .b_ready_o   (b_ready),
        .b_col_i     (b_col),
        .b_row_i     (b_row),
        .b_color_i   (b_color),
        .clr_valid_i (clr_valid),
        .clr_ready_o (clr_ready),
        .x_o         (x),
        .y_o         (y),
        .color_o     (color),
        .write_o     (write),
        .busy_o      (busy),
        .err_o       (err)
    );

    typedef struct {
        logic [3:0] col;
        logic [4:0] row;
        logic [8:0] clr;
        bit         exp_err;
        int         exp_x0;
        int         exp_y0;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // who: 0=A 1=B 2=clear. Returns one cycle after the accepting edge, valid dropped.
    task automatic wait_ready(input int who, input int budget, input string name);
        bit ok = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            #1;
            if ((who == 0 && a_ready) || (who == 1 && b_ready) || (who == 2 && clr_ready)) begin
                ok = 1;
                tick();
                if (who == 0) a_valid = 1'b0;
                else if (who == 1) b_valid = 1'b0;
                else clr_valid = 1'b0;
            end else begin
                tick();
            end
        end
        chk({name, "_accept_timeout"}, int'(ok), 1);
    endtask

    // Called one cycle after acceptance; compares the whole raster then the idle gap cycle.
    task automatic check_rect(input int x0, input int y0, input int w, input int h,
                              input logic [8:0] c, input string name);
        int bad = 0;
        for (int py = 0; py < h; py++) begin
            for (int px = 0; px < w; px++) begin
                if (write !== 1'b1 || busy !== 1'b1 || int'(x) != x0 + px ||
                    int'(y) != y0 + py || color !== c)
                    bad++;
                tick();
            end
        end
        chk({name, "_bad_pixels"}, bad, 0);
        chk({name, "_write_after"}, int'(write), 0);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    initial begin
        int grants[4];
        int gcyc[4];
        int ng;
        int nwr;
        int bad;

        vecs[0] = '{col: 4'd0,  row: 5'd0,  clr: 9'h1C0, exp_err: 0, exp_x0: 55,  exp_y0: 10};
        vecs[1] = '{col: 4'd9,  row: 5'd19, clr: 9'h03F, exp_err: 0, exp_x0: 100, exp_y0: 105};
        vecs[2] = '{col: 4'd3,  row: 5'd7,  clr: 9'h155, exp_err: 0, exp_x0: 70,  exp_y0: 45};
        vecs[3] = '{col: 4'd10, row: 5'd0,  clr: 9'h0AA, exp_err: 1, exp_x0: 0,   exp_y0: 0};
        vecs[4] = '{col: 4'd0,  row: 5'd20, clr: 9'h0AA, exp_err: 1, exp_x0: 0,   exp_y0: 0};
        vecs[5] = '{col: 4'd5,  row: 5'd12, clr: 9'h1FF, exp_err: 0, exp_x0: 80,  exp_y0: 70};

        // Reset values
        #3;
        chk("rst_x", int'(x), 0);
        chk("rst_y", int'(y), 0);
        chk("rst_color", int'(color), 0);
        chk("rst_write", int'(write), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        tick();
        tick();
        reset = 1'b0;

        // Reset in the middle of a cell
        a_col = 4'd2; a_row = 5'd2; a_color = 9'h123; a_valid = 1'b1;
        wait_ready(0, 10, "midrst");
        repeat (5) tick();
        chk("midrst_write_before", int'(write), 1);
        reset = 1'b1;
        #1;
        chk("midrst_write", int'(write), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err", int'(err), 0);
        nwr = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (write) nwr++;
        end
        chk("midrst_writes_in_reset", nwr, 0);
        a_col = 4'd0; a_row = 5'd0; a_color = 9'h1C0; a_valid = 1'b1;
        b_col = 4'd1; b_row = 5'd1; b_color = 9'h001; b_valid = 1'b1;
        reset = 1'b0;
        #1;
        chk("postrst_a_ready", int'(a_ready), 1);
        chk("postrst_b_ready", int'(b_ready), 0);
        b_valid = 1'b0;
        wait_ready(0, 10, "postrst");
        check_rect(55, 10, 5, 5, 9'h1C0, "postrst_cell");

        // Table of single A paints
        for (int v = 0; v < 6; v++) begin
            a_col = vecs[v].col; a_row = vecs[v].row; a_color = vecs[v].clr; a_valid = 1'b1;
            wait_ready(0, 10, $sformatf("vec%0d", v));
            if (vecs[v].exp_err) begin
                chk($sformatf("vec%0d_err", v), int'(err), 1);
                bad = 0;
                for (int i = 0; i < 4; i++) begin
                    if (write || busy) bad++;
                    if (i == 0) begin
                        tick();
                        chk($sformatf("vec%0d_err_drop", v), int'(err), 0);
                    end else begin
                        tick();
                    end
                end
                chk($sformatf("vec%0d_no_writes", v), bad, 0);
            end else begin
                chk($sformatf("vec%0d_noerr", v), int'(err), 0);
                check_rect(vecs[v].exp_x0, vecs[v].exp_y0, 5, 5, vecs[v].clr,
                           $sformatf("vec%0d", v));
            end
        end

        // Round robin with A and B held; last served was A so B goes first
        a_col = 4'd1; a_row = 5'd1; a_color = 9'h0F0; a_valid = 1'b1;
        b_col = 4'd2; b_row = 5'd2; b_color = 9'h00F; b_valid = 1'b1;
        ng = 0; nwr = 0; bad = 0;
        for (int c = 0; c < 200 && ng < 4; c++) begin
            #1;
            if (ng > 0 && write) nwr++;
            if (a_ready || b_ready) begin
                if (write) bad++;
                if (a_ready && b_ready) bad++;
                grants[ng] = b_ready ? 1 : 0;
                gcyc[ng] = c;
                ng++;
            end
            tick();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        chk("rr_grant_count", ng, 4);
        chk("rr_first_is_b", grants[0], 1);
        for (int i = 1; i < 4; i++) begin
            chk($sformatf("rr_alternate%0d", i), grants[i], 1 - grants[i-1]);
            chk($sformatf("rr_spacing%0d", i), gcyc[i] - gcyc[i-1], 26);
        end
        chk("rr_writes_between", nwr, 75);
        chk("rr_gap_violations", bad, 0);
        repeat (30) tick();

        // Clear, A and B together right after reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clr_valid = 1'b1;
        a_col = 4'd4; a_row = 5'd2; a_color = 9'h0AA; a_valid = 1'b1;
        b_col = 4'd1; b_row = 5'd1; b_color = 9'h111; b_valid = 1'b1;
        #1;
        chk("all3_clr_ready", int'(clr_ready), 1);
        chk("all3_a_ready", int'(a_ready), 0);
        chk("all3_b_ready", int'(b_ready), 0);
        wait_ready(2, 10, "clr");
        check_rect(55, 10, 50, 100, 9'd0, "clr");
        #1;
        chk("after_clr_a_ready", int'(a_ready), 1);
        chk("after_clr_b_ready", int'(b_ready), 0);
        wait_ready(0, 10, "after_clr_a");
        check_rect(75, 20, 5, 5, 9'h0AA, "after_clr_a");
        wait_ready(1, 10, "after_clr_b");
        check_rect(60, 15, 5, 5, 9'h111, "after_clr_b");

        // Fields changed while waiting: the value on the accept edge is painted
        b_col = 4'd0; b_row = 5'd0; b_color = 9'h007; b_valid = 1'b1;
        wait_ready(1, 10, "sample_b");
        a_col = 4'd2; a_row = 5'd3; a_color = 9'h0F0; a_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (a_ready) bad++;
            tick();
        end
        chk("sample_ready_while_busy", bad, 0);
        a_col = 4'd7;
        wait_ready(0, 40, "sample_a");
        check_rect(90, 25, 5, 5, 9'h0F0, "sample_a");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=%0d required=%0d", 1, 0);
        $fatal(1, "timeout");
    end

endmodule
